// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 4-digit display scan logic.
package display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  typedef struct packed {
    scan_state_t state;
    logic [1:0]  slot;
    logic        frame_start;
    logic        grant_b;
    logic        fair_pending;
  } scan_dbg_t;

  // Nearest enabled slot above 'slot', wrapping to the lowest; returns 'slot' if it is the only one.
  function automatic logic [1:0] next_slot(input logic [3:0] mask, input logic [1:0] slot);
    logic [1:0] r;
    logic [1:0] c;
    r = slot;
    for (int k = 3; k >= 1; k--) begin
      c = slot + 2'(k);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_arbiter.sv
// Frame-granular owner selection between timer source A and status source B.
module display_arbiter #(
  parameter int HOLD_FRAMES = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic req_b,
  output logic grant_b,
  output logic grant_next,
  output logic fair_pending
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic [HW-1:0] hold;
  logic [HW-1:0] hold_n;
  logic          fair_n;

  // Release of B is itself a frame step, so A always keeps the following frame;
  // fair_pending marks that guaranteed frame.
  always_comb begin
    grant_next = grant_b;
    hold_n     = hold;
    fair_n     = fair_pending;
    if (step) begin
      fair_n = 1'b0;
      if (!grant_b) begin
        if (req_b) begin
          grant_next = 1'b1;
          hold_n     = HW'(HOLD_FRAMES);
        end
      end else begin
        hold_n = hold - HW'(1);
        if (!req_b || hold_n == '0) begin
          grant_next = 1'b0;
          fair_n     = (hold_n == '0);
          hold_n     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_b      <= 1'b0;
      hold         <= '0;
      fair_pending <= 1'b0;
    end else begin
      grant_b      <= grant_next;
      hold         <= hold_n;
      fair_pending <= fair_n;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Scan FSM, per-frame digit snapshot and leading-zero suppression for the 4-digit display.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int HOLD_FRAMES  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_d3,
  input  logic [3:0] a_d2,
  input  logic [3:0] a_d1,
  input  logic [3:0] a_d0,
  input  logic [3:0] b_d3,
  input  logic [3:0] b_d2,
  input  logic [3:0] b_d1,
  input  logic [3:0] b_d0,
  input  logic       req_b,
  input  logic [3:0] digit_mask,
  input  logic       lzs_en,
  output logic [3:0] bcd,
  output logic [3:0] dig_en,
  output logic       blank,
  output logic       grant_b,
  output logic       frame_done,
  output scan_dbg_t  dbg
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  scan_state_t     state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      slot, slot_n;
  logic            frame_start, frame_start_n;
  logic            loaded;
  logic [3:0][3:0] snap;
  logic [3:0]      lz;
  logic [3:0]      show_code;
  logic            frame_done_n;
  logic            grant_next;
  logic            fair_pending;

  display_arbiter #(.HOLD_FRAMES(HOLD_FRAMES)) u_arbiter (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (frame_done),
    .req_b        (req_b),
    .grant_b      (grant_b),
    .grant_next   (grant_next),
    .fair_pending (fair_pending)
  );

  // frame_start marks a BLANK that opens a frame, so the lowest slot of the
  // mask in force at that moment is the first one shown.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt + CW'(1);
    slot_n        = slot;
    frame_start_n = frame_start;
    if (state == BLANK) begin
      if (digit_mask == 4'b0000) begin
        cnt_n         = '0;
        frame_start_n = 1'b1;
      end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
        state_n       = SHOW;
        cnt_n         = '0;
        frame_start_n = 1'b0;
        if (frame_start)
          slot_n = next_slot(digit_mask, 2'd3);
        else if (!digit_mask[slot])
          slot_n = next_slot(digit_mask, slot);
      end
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      state_n       = BLANK;
      cnt_n         = '0;
      slot_n        = next_slot(digit_mask, slot);
      frame_start_n = (slot_n <= slot);
    end
  end

  // Outputs are registered from next-state values so they line up with the FSM state.
  always_comb begin
    lz[3] = (snap[3] == 4'd0);
    lz[2] = lz[3] && (snap[2] == 4'd0);
    lz[1] = lz[2] && (snap[1] == 4'd0);
    lz[0] = lz[1] && (snap[0] == 4'd0);
    show_code = (lzs_en && slot_n != 2'd0 && lz[slot_n]) ? BLANK_CODE : snap[slot_n];
    frame_done_n = (state_n == SHOW) && (cnt_n == CW'(SCAN_DIV - 1)) &&
                   (digit_mask != 4'b0000) && (next_slot(digit_mask, slot_n) <= slot_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      slot        <= 2'd0;
      frame_start <= 1'b1;
      loaded      <= 1'b0;
      snap        <= '0;
      bcd         <= BLANK_CODE;
      dig_en      <= 4'b0000;
      blank       <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      slot        <= slot_n;
      frame_start <= frame_start_n;
      if (!loaded || frame_done) begin
        loaded <= 1'b1;
        snap   <= grant_next ? {b_d3, b_d2, b_d1, b_d0} : {a_d3, a_d2, a_d1, a_d0};
      end
      dig_en     <= (state_n == SHOW) ? (4'b0001 << slot_n) : 4'b0000;
      blank      <= (state_n == BLANK);
      bcd        <= (state_n == SHOW) ? show_code : BLANK_CODE;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    dbg.state        = state;
    dbg.slot         = slot;
    dbg.frame_start  = frame_start;
    dbg.grant_b      = grant_b;
    dbg.fair_pending = fair_pending;
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Frame-level reference model bench for display_scan_controller.
module tb_display_scan_controller;
  import display_pkg::*;

  localparam int SD = 4;
  localparam int BC = 2;
  localparam int HF = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_val;
  logic [15:0] b_val;
  logic        req_b;
  logic [3:0]  digit_mask;
  logic        lzs_en;
  logic [3:0]  bcd;
  logic [3:0]  dig_en;
  logic        blank;
  logic        grant_b;
  logic        frame_done;
  scan_dbg_t   dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the display will show in the coming frame.
  logic [15:0] m_snap;
  logic        m_grant;
  int          m_left;

  display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .HOLD_FRAMES(HF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_d3       (a_val[15:12]),
    .a_d2       (a_val[11:8]),
    .a_d1       (a_val[7:4]),
    .a_d0       (a_val[3:0]),
    .b_d3       (b_val[15:12]),
    .b_d2       (b_val[11:8]),
    .b_d1       (b_val[7:4]),
    .b_d0       (b_val[3:0]),
    .req_b      (req_b),
    .digit_mask (digit_mask),
    .lzs_en     (lzs_en),
    .bcd        (bcd),
    .dig_en     (dig_en),
    .blank      (blank),
    .grant_b    (grant_b),
    .frame_done (frame_done),
    .dbg        (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plays one frame: builds the expected per-cycle outputs from the model,
  // compares every cycle at the falling edge, applies at most one digit change
  // and one req_b change, then advances the model at frame end.
  task automatic play_frame(input logic [3:0] mask, input int chg_at, input logic [15:0] na,
                            input logic [15:0] nb, input int req_at, input logic nreq);
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;
    logic [10:0] obs;
    logic [3:0]  code;
    int          top_slot;
    int          cyc;
    digit_mask = mask;
    top_slot = -1;
    for (int s = 0; s < 4; s++) if (mask[s]) top_slot = s;
    for (int s = 0; s < 4; s++) begin
      if (mask[s]) begin
        code = m_snap[s*4 +: 4];
        if (lzs_en && s != 0 && (m_snap >> (s*4)) == 16'd0) code = 4'hF;
        for (int k = 0; k < BC; k++) exp_q.push_back({m_grant, 1'b0, 1'b1, 4'b0000, 4'hF});
        for (int k = 0; k < SD; k++)
          exp_q.push_back({m_grant, (s == top_slot && k == SD - 1), 1'b0, 4'(1 << s), code});
      end
    end
    if (mask == 4'b0000)
      for (int k = 0; k < 20; k++) exp_q.push_back({m_grant, 1'b0, 1'b1, 4'b0000, 4'hF});
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs = {grant_b, frame_done, blank, dig_en, bcd};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL scan_cycle mask=%b cycle=%0d got grant/fd/blank/dig/bcd=%b required %b",
                 mask, cyc, obs, exp_v);
      end
      if (cyc == chg_at) begin
        a_val = na;
        b_val = nb;
      end
      if (cyc == req_at) req_b = nreq;
      cyc++;
      @(negedge clk);
    end
    if (mask != 4'b0000) begin
      if (!m_grant) begin
        if (req_b) begin
          m_grant = 1'b1;
          m_left  = HF;
        end
      end else begin
        m_left--;
        if (!req_b || m_left == 0) m_grant = 1'b0;
      end
      m_snap = m_grant ? b_val : a_val;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dig_en !== 4'b0000) begin errors++; $display("FAIL reset_dig_en got %b required 0000", dig_en); end
    checks++;
    if (bcd !== 4'hF) begin errors++; $display("FAIL reset_bcd got %h required f", bcd); end
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b required 1", blank); end
    checks++;
    if (grant_b !== 1'b0) begin errors++; $display("FAIL reset_grant_b got %b required 0", grant_b); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b required 0", frame_done); end
    rst_n   = 1'b1;
    m_snap  = a_val;
    m_grant = 1'b0;
    m_left  = 0;
  endtask

  task automatic test_full_scan();
    repeat (2) play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
  endtask

  task automatic test_masked_scan();
    repeat (2) play_frame(4'b1010, -1, a_val, b_val, -1, 1'b0);
    play_frame(4'b0000, -1, a_val, b_val, -1, 1'b0);
    play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
  endtask

  task automatic test_lzs();
    lzs_en = 1'b1;
    play_frame(4'b1111, 3, 16'h0007, b_val, -1, 1'b0);
    play_frame(4'b1111, 3, 16'h0000, b_val, -1, 1'b0);
    play_frame(4'b1111, 3, 16'h0305, b_val, -1, 1'b0);
    play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
    lzs_en = 1'b0;
  endtask

  task automatic test_arbitration();
    b_val = 16'(($urandom_range(0, 9) << 12) | ($urandom_range(0, 9) << 8) | ($urandom_range(0, 9) << 4) | 9);
    play_frame(4'b1111, -1, a_val, b_val, 5, 1'b1);
    repeat (3) play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
    play_frame(4'b1111, -1, a_val, b_val, 7, 1'b0);
    play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
  endtask

  task automatic test_anti_tearing();
    for (int f = 0; f < 3; f++)
      play_frame(4'b1111, $urandom_range(2, 23), 16'($urandom()), b_val, -1, 1'b0);
    play_frame(4'b1111, -1, a_val, b_val, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      lzs_en = 1'($urandom_range(0, 1));
      play_frame(4'($urandom_range(1, 15)), $urandom_range(0, 23), 16'($urandom()), 16'($urandom()),
                 $urandom_range(0, 23), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_show();
    bit found;
    found = 1'b0;
    digit_mask = 4'b1111;
    for (int i = 0; i < 50 && !found; i++) begin
      if (dig_en != 4'b0000) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_show_wait got no lit digit within 50 cycles required a SHOW cycle");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dig_en !== 4'b0000) begin errors++; $display("FAIL async_reset_dig_en got %b required 0000", dig_en); end
    checks++;
    if (blank !== 1'b1 || bcd !== 4'hF) begin
      errors++;
      $display("FAIL async_reset_blank got blank=%b bcd=%h required blank=1 bcd=f", blank, bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    a_val      = 16'h4321;
    b_val      = 16'($urandom());
    req_b      = 1'b0;
    digit_mask = 4'b1111;
    lzs_en     = 1'b0;
    test_reset();
    test_full_scan();
    test_masked_scan();
    test_lzs();
    test_arbitration();
    test_anti_tearing();
    test_random();
    test_reset_mid_show();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
